// File: rtl/approx_mult.sv
// Registered 8x8 unsigned approximate multiplier: low APPROX_COLS columns OR-reduced, upper columns summed exactly.
// Define APPROX_MULT_EXACT_EN to compile out the approximation and register the exact product.
module approx_mult #(
  parameter int APPROX_COLS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] o
);

`ifdef APPROX_MULT_EXACT_EN
  localparam int EFF_COLS = 0;
`else
  localparam int EFF_COLS = APPROX_COLS;
`endif

  localparam logic [15:0] LOWER_MASK = 16'((32'd1 << EFF_COLS) - 32'd1);

  // 3:2 carry-save compressor over whole rows; returns {sum, carry}
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] maj;
    s   = x ^ y ^ z;
    maj = (x & y) | (x & z) | (y & z);
    return {s, maj << 1};
  endfunction

  logic [15:0] pp_s [8];
  logic [15:0] up_s [8];
  logic [15:0] lower_s;
  logic [15:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s, s3_s, c3_s, s4_s, c4_s, s5_s, c5_s;
  logic [15:0] upper_s;
  logic [15:0] f_s;
  logic [15:0] o_r;

  // partial-product rows, split into OR-reduced low field and exactly summed high field
  always_comb begin
    lower_s = 16'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        pp_s[i] = 16'({8'd0, a} << i);
      end else begin
        pp_s[i] = 16'd0;
      end
      up_s[i] = pp_s[i] & ~LOWER_MASK;
      lower_s = lower_s | (pp_s[i] & LOWER_MASK);
    end
  end

  // carry-save tree 8 -> 6 -> 4 -> 3 -> 2 rows, then carry-propagate add
  always_comb begin
    {s0_s, c0_s} = csa(up_s[0], up_s[1], up_s[2]);
    {s1_s, c1_s} = csa(up_s[3], up_s[4], up_s[5]);
    {s2_s, c2_s} = csa(s0_s, c0_s, s1_s);
    {s3_s, c3_s} = csa(c1_s, up_s[6], up_s[7]);
    {s4_s, c4_s} = csa(s2_s, c2_s, s3_s);
    {s5_s, c5_s} = csa(s4_s, c4_s, c3_s);
    upper_s      = s5_s + c5_s;
    // upper sum has zeros in every approximated column, so OR concatenates the fields
    f_s          = upper_s | lower_s;
  end

  // output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r <= 16'd0;
    end else begin
      o_r <= f_s;
    end
  end

  assign o = o_r;

endmodule

// File: tb/tb_approx_mult.sv
// Self-checking bench for approx_mult: directed squares, reset behaviour, throughput and a random sweep
// against a column-count reference model; a second instance with APPROX_COLS=0 checks the exact path.
module tb_approx_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] o;
  logic [15:0] o_exact;

  int n_cmp = 0;
  int n_err = 0;

`ifdef APPROX_MULT_EXACT_EN
  localparam int COLS = 0;
`else
  localparam int COLS = 8;
`endif

  approx_mult #(.APPROX_COLS(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .o(o)
  );

  approx_mult #(.APPROX_COLS(0)) dut_exact (
    .clk(clk), .rst(rst), .a(a), .b(b), .o(o_exact)
  );

  always #5 clk = ~clk;

  // count set pp bits per column, then OR-reduce low columns and weight the rest
  function automatic int ref_f(int x, int y, int cols);
    int cnt [15];
    int r;
    for (int c = 0; c < 15; c++) cnt[c] = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (((x >> j) & 1) == 1 && ((y >> i) & 1) == 1) cnt[i+j]++;
    r = 0;
    for (int c = 0; c < 15; c++) begin
      if (c < cols) r += (cnt[c] > 0) ? (1 << c) : 0;
      else          r += cnt[c] << c;
    end
    return r;
  endfunction

  task automatic test_reset();
    int exp;
    @(negedge clk);
    a = 8'd255; b = 8'd255; rst = 1'b1;
    #1;
    n_cmp++;
    if (o !== 16'd0) begin n_err++; $display("FAIL reset_async o=%0d want=0", o); end
    @(posedge clk); #1;
    n_cmp++;
    if (o !== 16'd0) begin n_err++; $display("FAIL reset_held o=%0d want=0", o); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp = (COLS == 0) ? 65025 : 63487;
    n_cmp++;
    if (o !== 16'(exp)) begin n_err++; $display("FAIL reset_release o=%0d want=%0d", o, exp); end
    n_cmp++;
    if (o_exact !== 16'd65025) begin n_err++; $display("FAIL exact_255 o=%0d want=65025", o_exact); end
  endtask

  task automatic test_squares();
    int ops  [7] = '{10, 25, 40, 42, 35, 0, 1};
    int opb  [7] = '{10, 25, 40, 42, 35, 200, 200};
    int want [7] = '{84, 473, 1600, 1620, 1127, 0, 200};
    int exp;
    for (int k = 0; k < 7; k++) begin
      a = 8'(ops[k]); b = 8'(opb[k]);
      @(posedge clk); #1;
      exp = (COLS == 0) ? ops[k] * opb[k] : want[k];
      n_cmp++;
      if (o !== 16'(exp)) begin
        n_err++; $display("FAIL square %0d*%0d o=%0d want=%0d", ops[k], opb[k], o, exp);
      end
      n_cmp++;
      if (o_exact !== 16'(ops[k] * opb[k])) begin
        n_err++; $display("FAIL exact %0d*%0d o=%0d want=%0d", ops[k], opb[k], o_exact, ops[k] * opb[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pa, pb;
    pa = int'(a); pb = int'(b);
    for (int k = 0; k < 5; k++) begin
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      @(posedge clk); #1;
      n_cmp++;
      if (o !== 16'(ref_f(int'(a), int'(b), COLS))) begin
        n_err++; $display("FAIL b2b %0d*%0d o=%0d want=%0d", a, b, o, ref_f(int'(a), int'(b), COLS));
      end
      n_cmp++;
      if (o === 16'(ref_f(pa, pb, COLS)) && ref_f(pa, pb, COLS) != ref_f(int'(a), int'(b), COLS)) begin
        n_err++; $display("FAIL b2b_stale o=%0d still from %0d*%0d", o, pa, pb);
      end
      pa = int'(a); pb = int'(b);
    end
  endtask

  task automatic test_mid_reset();
    a = 8'd42; b = 8'd42;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o !== 16'd0) begin n_err++; $display("FAIL mid_reset o=%0d want=0", o); end
    n_cmp++;
    if (o_exact !== 16'd0) begin n_err++; $display("FAIL mid_reset_exact o=%0d want=0", o_exact); end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (o !== 16'(ref_f(42, 42, COLS))) begin
      n_err++; $display("FAIL mid_release o=%0d want=%0d", o, ref_f(42, 42, COLS));
    end
  endtask

  task automatic test_random();
    int exp;
    for (int k = 0; k < 300; k++) begin
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      @(posedge clk); #1;
      exp = ref_f(int'(a), int'(b), COLS);
      n_cmp++;
      if (o !== 16'(exp)) begin
        n_err++; $display("FAIL rand %0d*%0d o=%0d want=%0d", a, b, o, exp);
      end
      n_cmp++;
      if (int'(o) > int'(a) * int'(b)) begin
        n_err++; $display("FAIL bound %0d*%0d o=%0d exceeds %0d", a, b, o, int'(a) * int'(b));
      end
      n_cmp++;
      if (o_exact !== 16'(int'(a) * int'(b))) begin
        n_err++; $display("FAIL rand_exact %0d*%0d o=%0d want=%0d", a, b, o_exact, int'(a) * int'(b));
      end
    end
  endtask

  initial begin
    rst = 1'b0; a = 8'd0; b = 8'd0;
    test_reset();
    test_squares();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
